// File: rtl/xadc_speed_ctrl.sv
// xadc_speed_ctrl: averages XADC DRP samples into a ball speed committed at frame boundaries.
// Optional XADC_SPEED_HYST_EN: commit only after two consecutive batches agree.
module xadc_speed_ctrl #(
  parameter logic [6:0]  CHAN_ADDR   = 7'h03,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned SCALE_SHIFT = 9,
  parameter int unsigned MIN_SPEED   = 1,
  parameter int unsigned MAX_SPEED   = 8,
  parameter int unsigned RESET_SPEED = 2,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        eoc,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [6:0]  drp_daddr,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [7:0]  speed,
  output logic        speed_upd,
  output logic [7:0]  err_cnt
);
  localparam int AW = 12 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, REQ, WAIT_RDY, ACCUM, MAP} state_t;
  state_t r_state, w_next;
  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_tmo;
  logic [11:0]   r_sample;
  logic [7:0]    r_pend;
  logic          r_pend_valid;
  logic          w_timeout, w_last, w_tick, w_unused;
  logic [11:0]   w_avg;
  logic [31:0]   w_q;
  logic [7:0]    w_m;
  assign w_timeout = r_tmo == TW'(TIMEOUT - 1);
  assign w_last    = r_cnt == CW'((1 << AVG_LOG2) - 1);
  assign w_tick    = pix_y == 10'd480 && pix_x == 10'd0;
  assign w_avg     = 12'(r_acc >> AVG_LOG2);
  assign w_q       = 32'(w_avg >> SCALE_SHIFT) + 32'(MIN_SPEED);
  assign w_m       = 8'(w_q < 32'(MIN_SPEED) ? 32'(MIN_SPEED) : w_q > 32'(MAX_SPEED) ? 32'(MAX_SPEED) : w_q);
  assign w_unused  = ^drp_do[3:0];
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  always_comb begin
    w_next    = r_state;
    drp_den   = r_state == REQ;
    drp_dwe   = 1'b0;
    drp_daddr = CHAN_ADDR;
    unique case (r_state)
      IDLE:     w_next = eoc ? REQ : IDLE;
      REQ:      w_next = WAIT_RDY;
      WAIT_RDY: w_next = drp_drdy ? ACCUM : w_timeout ? IDLE : WAIT_RDY;
      ACCUM:    w_next = w_last ? MAP : IDLE;
      MAP:      w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end
`ifdef XADC_SPEED_HYST_EN
  logic [7:0] r_prev;
  always_ff @(posedge clk or posedge reset)
    if (reset)              r_prev <= 8'(RESET_SPEED);
    else if (r_state == MAP) r_prev <= w_m;
  wire w_accept = w_m == r_prev;
`else
  wire w_accept = 1'b1;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_tmo        <= '0;
      r_sample     <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      speed        <= 8'(RESET_SPEED);
      speed_upd    <= 1'b0;
      err_cnt      <= '0;
    end else begin
      speed_upd <= 1'b0;
      if (r_state == REQ) r_tmo <= '0;
      if (r_state == WAIT_RDY) begin
        if (drp_drdy)       r_sample <= drp_do[15:4];
        else if (w_timeout) err_cnt  <= err_cnt + 8'(err_cnt != 8'hFF);
        else                r_tmo    <= r_tmo + 1'b1;
      end
      if (r_state == ACCUM) begin
        r_acc <= r_acc + AW'(r_sample);
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_tick && r_pend_valid) begin
        speed        <= r_pend;
        r_pend_valid <= 1'b0;
        speed_upd    <= r_pend != speed;
      end
      // A fresh batch result wins over the commit clear, deferring it to the next tick.
      if (r_state == MAP) begin
        r_acc <= '0;
        r_cnt <= '0;
        if (w_accept) begin
          r_pend       <= w_m;
          r_pend_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/xadc_speed_ctrl.md
Name: xadc_speed_ctrl

Overview:
- Upstream stage of the pong graphics block. Reads one XADC channel (potentiometer) over the DRP port each time the XADC signals end-of-conversion, averages 2^AVG_LOG2 samples, and maps the average to a small ball-speed value.
- Drives the 8-bit `speed` input of the animation block.
- The speed output changes only at a frame boundary, so the ball velocity never changes in the middle of a frame.

Parameters:
- CHAN_ADDR, 7'h03: DRP address of the XADC status register that is read (VAUX/VP result register).
- AVG_LOG2, 2: log2 of the number of samples averaged per update (range 0..4).
- SCALE_SHIFT, 9: right shift applied to the 12-bit average before offset.
- MIN_SPEED, 1: speed for a zero input; also the lower clamp.
- MAX_SPEED, 8: upper clamp on speed.
- RESET_SPEED, 2: speed value held from reset until the first update.
- TIMEOUT, 64: cycles to wait for drp_drdy before the read is abandoned.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- eoc  in  1  XADC end-of-conversion, one-cycle pulse
- drp_den  out  1  DRP enable, one-cycle pulse
- drp_dwe  out  1  DRP write enable, tied 0 (read only)
- drp_daddr  out  7  DRP address
- drp_do  in  16  DRP read data; result in bits [15:4]
- drp_drdy  in  1  DRP data ready, one-cycle pulse
- pix_x  in  10  current pixel column from the VGA sync block
- pix_y  in  10  current pixel row from the VGA sync block
- speed  out  8  ball speed to the animation block
- speed_upd  out  1  one-cycle pulse on the cycle `speed` changes value
- err_cnt  out  8  count of DRP timeouts, saturating at 255

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-high.
- Reset values:
  - FSM in IDLE; drp_den=0, drp_dwe=0, drp_daddr=CHAN_ADDR.
  - speed=RESET_SPEED, speed_upd=0, err_cnt=0.
  - Accumulator, sample counter and timeout counter cleared; pend_valid=0.
- FSM states: IDLE, REQ, WAIT_RDY, ACCUM, MAP.
  - IDLE: on eoc=1 go to REQ.
  - REQ: drp_den=1 for exactly this cycle, drp_daddr=CHAN_ADDR, drp_dwe=0. Go to WAIT_RDY and clear the timeout counter.
  - WAIT_RDY: on drp_drdy=1, capture sample=drp_do[15:4] and go to ACCUM.
    - If TIMEOUT cycles pass without drdy, increment err_cnt (saturating) and return to IDLE.
    - On timeout the accumulator and sample count are kept unchanged.
  - ACCUM: acc += sample, where acc is (12+AVG_LOG2) bits wide.
    - Increment the sample count.
    - If the count reaches 2^AVG_LOG2, go to MAP; otherwise go to IDLE.
  - MAP:
    - avg = acc >> AVG_LOG2.
    - m = (avg >> SCALE_SHIFT) + MIN_SPEED, clamped to [MIN_SPEED, MAX_SPEED].
    - pend = m, pend_valid=1.
    - Clear acc and the sample count, then go to IDLE.
- eoc outside IDLE is ignored; no request is queued.
- drp_drdy outside WAIT_RDY is ignored.
- Frame-boundary commit:
  - Frame tick = (pix_y==480 && pix_x==0). This is one line before the animation block's refresh tick at row 481.
  - On the frame tick with pend_valid=1: speed<=pend, pend_valid<=0, and speed_upd=1 if pend differs from the old speed.
  - On the frame tick with pend_valid=0: speed is held.
  - If MAP and the frame tick occur in the same cycle, the new pend is committed at the next frame tick, not this one.
- Latency: from the final eoc of a batch to pend_valid is 4 cycles plus the DRP response time. Commit then waits for the next frame tick.
- Default mapping (AVG_LOG2=2, SCALE_SHIFT=9, MIN=1, MAX=8):
  - avg 0..511 gives speed 1.
  - avg 3584..4095 gives speed 8.
- Reset mid-operation (any state) returns everything to the reset values on the next clock edge. Partial sums are discarded.

Optional Feature:
- Macro: XADC_SPEED_HYST_EN.
- When defined: MAP sets pend_valid only when m equals the mapped value from the previous batch. This requires two consecutive agreeing batches, which suppresses pot jitter. The previous-batch value resets to RESET_SPEED.
- When undefined: every batch sets pend_valid, and no previous-batch register exists.

Test Plan:
- Full-scale input:
  - Stimulus: 4 eoc pulses, each answered with drdy 3 cycles after den and drp_do=16'hFFF0, then frame tick.
  - Response: speed=8 and speed_upd=1 at the tick. With XADC_SPEED_HYST_EN, speed=8 only after 8 samples.
- Zero input and update gating:
  - Stimulus: drp_do=16'h0000 for 4 samples, then a second batch of 4 with no frame tick in between.
  - Response: speed stays at its previous value until the tick, then becomes 1. Only one speed_upd pulse occurs.
- Timeout:
  - Stimulus: eoc, no drdy for 64 cycles.
  - Response: FSM back in IDLE, err_cnt=1, sample count unchanged. The next 4 good samples of 16'h8000 (avg 2048) give speed 5.
- eoc while busy:
  - Stimulus: a second eoc during WAIT_RDY.
  - Response: no second drp_den pulse; exactly one den per accepted eoc.
- Reset mid-read:
  - Stimulus: assert reset during WAIT_RDY after 3 samples of 16'hFFF0.
  - Response: speed=2 and err_cnt=0. The next 4 samples of 16'h0000 give speed 1 at the next tick.
- Simultaneous MAP and frame tick:
  - Stimulus: align MAP with pix_y=480, pix_x=0.
  - Response: speed unchanged on that tick and committed at the following frame tick.
